// File: rtl/sram_like_responder_pkg.sv
// Shared types and constants for the SRAM-like responder: size codes, LFSR
// constants and the response-queue entry layout.
package sram_like_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Fibonacci taps 16,14,13,11 map to state bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int ENTRY_W = 1 + 32 + 4;

  typedef struct packed {
    logic        is_wr;
    logic [31:0] data;
    logic [3:0]  age;
  } entry_t;

  function automatic logic lfsr_fb(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/sram_like_resp_queue.sv
// In-order circular response queue; every slot's age counts up each cycle and
// saturates at 15, a pushed entry starts at age 0.
module sram_like_resp_queue
  import sram_like_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] push_entry,
  output logic               full,
  output logic               empty,
  output logic [ENTRY_W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t             mem [DEPTH];
  entry_t             pe;
  logic [PTR_W-1:0]   rptr;
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W:0]     count;

  assign pe    = push_entry;
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stale slots keep aging too; they are overwritten with age 0 on push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && wptr == PTR_W'(i)) begin
        mem[i].is_wr <= pe.is_wr;
        mem[i].data  <= pe.data;
        mem[i].age   <= 4'd0;
      end else if (mem[i].age != 4'hF) begin
        mem[i].age <= mem[i].age + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like req/addr_ok/data_ok responder with internal RAM and bounded in-order
// response queue; SRAM_LIKE_RAND_DELAY_EN adds LFSR-driven handshake stalls.
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MAX_OUTST = 4,
  parameter int RESP_LAT  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        busy
);

  logic [31:0]        ram [2**ADDR_W];
  logic [ADDR_W-1:0]  idx;
  logic               q_full;
  logic               q_empty;
  logic [ENTRY_W-1:0] q_head;
  entry_t             head;
  entry_t             push_e;
  logic               stall_a;
  logic               stall_d;
  logic               unused_bits;

  assign idx  = addr[ADDR_W+1:2];
  assign head = q_head;

`ifdef SRAM_LIKE_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[14:0], lfsr_fb(lfsr)};
  end

  assign stall_a = (lfsr[1:0] == 2'b11);
  assign stall_d = (lfsr[3:2] == 2'b11);
`else
  assign stall_a = 1'b0;
  assign stall_d = 1'b0;
`endif

  // Full blocks acceptance even when the head retires this cycle.
  assign addr_ok = resetn & req & ~q_full & ~stall_a;
  assign data_ok = resetn & ~q_empty & (head.age >= 4'(RESP_LAT-1)) & ~stall_d;
  assign rdata   = (~q_empty & ~head.is_wr) ? head.data : 32'd0;
  assign busy    = ~q_empty;

  always_comb begin
    push_e       = '0;
    push_e.is_wr = wr;
    push_e.data  = wr ? 32'd0 : ram[idx];
    push_e.age   = 4'd0;
  end

  // Reads capture RAM at accept, so both directions take effect in issue order.
  always_ff @(posedge clk) begin
    if (addr_ok && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) ram[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  sram_like_resp_queue #(.DEPTH(MAX_OUTST)) u_queue (
    .clk        (clk),
    .resetn     (resetn),
    .push       (addr_ok),
    .pop        (data_ok),
    .push_entry (push_e),
    .full       (q_full),
    .empty      (q_empty),
    .head       (q_head)
  );

  assign unused_bits = ^{size == SZ_WORD, size == SZ_HALF, size == SZ_BYTE,
                         addr[31:ADDR_W+2], addr[1:0]};

endmodule

// File: tb/tb_sram_like_responder.sv
// Scoreboard bench: a fast instance (RESP_LAT=2) and a slow one (RESP_LAT=15).
module tb_sram_like_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req   [2];
  logic        wr    [2];
  logic [1:0]  size  [2];
  logic [3:0]  wstrb [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        addr_ok [2];
  logic        data_ok [2];
  logic [31:0] rdata   [2];
  logic        busy    [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] exp_d0 [$];
  logic [31:0] exp_d1 [$];
  int          acc_c0 [$];
  int          acc_c1 [$];
  int          last0 = -100;
  int          last1 = -100;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_like_responder #(.ADDR_W(12), .MAX_OUTST(4), .RESP_LAT(2)) u_fast (
    .clk(clk), .resetn(resetn), .req(req[0]), .wr(wr[0]), .size(size[0]),
    .wstrb(wstrb[0]), .addr(addr[0]), .wdata(wdata[0]), .addr_ok(addr_ok[0]),
    .data_ok(data_ok[0]), .rdata(rdata[0]), .busy(busy[0])
  );

  sram_like_responder #(.ADDR_W(12), .MAX_OUTST(4), .RESP_LAT(15)) u_slow (
    .clk(clk), .resetn(resetn), .req(req[1]), .wr(wr[1]), .size(size[1]),
    .wstrb(wstrb[1]), .addr(addr[1]), .wdata(wdata[1]), .addr_ok(addr_ok[1]),
    .data_ok(data_ok[1]), .rdata(rdata[1]), .busy(busy[1])
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h required=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Response monitors: pop the oldest expectation whenever data_ok is seen.
  // Expected cycle is accept+latency, or one after the previous response.
  always @(negedge clk) begin : mon0
    logic [31:0] d;
    int a, e;
    if (data_ok[0]) begin
      if (exp_d0.size() == 0) begin
        total++; bad++;
        $display("FAIL unexp_resp0: data_ok=1 required=0 (cycle %0d)", cyc);
      end else begin
        d = exp_d0.pop_front();
        a = acc_c0.pop_front();
        e = (a + 2 > last0 + 1) ? a + 2 : last0 + 1;
        last0 = cyc;
        chk("rdata_fast", rdata[0], d);
        chk("resp_cycle_fast", 32'(cyc), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [31:0] d;
    int a, e;
    if (data_ok[1]) begin
      if (exp_d1.size() == 0) begin
        total++; bad++;
        $display("FAIL unexp_resp1: data_ok=1 required=0 (cycle %0d)", cyc);
      end else begin
        d = exp_d1.pop_front();
        a = acc_c1.pop_front();
        e = (a + 15 > last1 + 1) ? a + 15 : last1 + 1;
        last1 = cyc;
        chk("rdata_slow", rdata[1], d);
        chk("resp_cycle_slow", 32'(cyc), 32'(e));
      end
    end
  end

  // Hold a request until accepted; exp is the response data (0 for writes).
  task automatic issue(input int k, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] exp, input int exp_wait);
    int waits = 0;
    @(posedge clk); #1;
    req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = wd; wstrb[k] = st; size[k] = 2'd2;
    while (1) begin
      @(negedge clk);
      if (addr_ok[k]) break;
      waits++;
      if (waits >= 40) break;
    end
    if (addr_ok[k]) begin
      if (k == 0) begin exp_d0.push_back(exp); acc_c0.push_back(cyc); end
      else        begin exp_d1.push_back(exp); acc_c1.push_back(cyc); end
    end
    chk(k == 0 ? "accept_wait_fast" : "accept_wait_slow", 32'(waits), 32'(exp_wait));
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic drain(input int k);
    int n = 0;
    idle(1);
    while (busy[k] && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_busy", 32'(busy[k]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; size[k] = 2'd0; wstrb[k] = 4'h0;
      addr[k] = 32'd0; wdata[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_addr_ok", 32'(addr_ok[k]), 32'd0);
      chk("rst_data_ok", 32'(data_ok[k]), 32'd0);
      chk("rst_rdata", rdata[k], 32'd0);
      chk("rst_busy", 32'(busy[k]), 32'd0);
    end
    @(posedge clk); #1;
    resetn = 1'b1;

    // Fast instance: single read timing, byte/half merges, aliasing.
    issue(0, 1'b1, 32'h0000_000C, 32'h1234_5678, 4'hF, 32'd0, 0);
    drain(0);
    issue(0, 1'b0, 32'h0000_000C, 32'd0, 4'h0, 32'h1234_5678, 0);
    issue(0, 1'b0, 32'h0000_000F, 32'd0, 4'h0, 32'h1234_5678, 0);
    issue(0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF, 32'd0, 0);
    issue(0, 1'b1, 32'h0000_0010, 32'h00AB_0000, 4'b0100, 32'd0, 0);
    issue(0, 1'b0, 32'h0000_0010, 32'd0, 4'h0, 32'hFFAB_FFFF, 0);
    issue(0, 1'b1, 32'h0000_0010, 32'h0000_1234, 4'b0011, 32'd0, 0);
    issue(0, 1'b1, 32'h0000_0010, 32'h5555_5555, 4'b0000, 32'd0, 0);
    issue(0, 1'b0, 32'h0000_0010, 32'd0, 4'h0, 32'hFFAB_1234, 0);
    issue(0, 1'b0, 32'hFFFF_C010, 32'd0, 4'h0, 32'hFFAB_1234, 0);
    issue(0, 1'b1, 32'h0000_4004, 32'hDEAD_BEEF, 4'hF, 32'd0, 0);
    issue(0, 1'b0, 32'h0000_0004, 32'd0, 4'h0, 32'hDEAD_BEEF, 0);
    drain(0);

    // Slow instance: fill the queue, full-while-retiring, in-order drain.
    issue(1, 1'b1, 32'h0000_0020, 32'h1111_1111, 4'hF, 32'd0, 0);
    issue(1, 1'b1, 32'h0000_0024, 32'h2222_2222, 4'hF, 32'd0, 0);
    issue(1, 1'b1, 32'h0000_0028, 32'h3333_3333, 4'hF, 32'd0, 0);
    issue(1, 1'b1, 32'h0000_002C, 32'h4444_4444, 4'hF, 32'd0, 0);
    drain(1);
    issue(1, 1'b0, 32'h0000_0020, 32'd0, 4'h0, 32'h1111_1111, 0);
    issue(1, 1'b0, 32'h0000_0024, 32'd0, 4'h0, 32'h2222_2222, 0);
    issue(1, 1'b0, 32'h0000_0028, 32'd0, 4'h0, 32'h3333_3333, 0);
    issue(1, 1'b0, 32'h0000_002C, 32'd0, 4'h0, 32'h4444_4444, 0);
    issue(1, 1'b0, 32'h0000_0020, 32'd0, 4'h0, 32'h1111_1111, 12);
    drain(1);

    // Reset with three reads outstanding: they must never respond.
    issue(1, 1'b0, 32'h0000_0020, 32'd0, 4'h0, 32'h1111_1111, 0);
    issue(1, 1'b0, 32'h0000_0024, 32'd0, 4'h0, 32'h2222_2222, 0);
    issue(1, 1'b0, 32'h0000_0028, 32'd0, 4'h0, 32'h3333_3333, 0);
    idle(2);
    @(posedge clk); #1;
    resetn = 1'b0;
    exp_d1.delete(); acc_c1.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy[1]), 32'd0);
    chk("post_rst_data_ok", 32'(data_ok[1]), 32'd0);
    idle(20);
    issue(1, 1'b0, 32'h0000_0024, 32'd0, 4'h0, 32'h2222_2222, 0);
    drain(1);
    idle(3);

    chk("sb_left_fast", 32'(exp_d0.size()), 32'd0);
    chk("sb_left_slow", 32'(exp_d1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
